// File: rtl/fp_align_pkg.sv
// Shared definitions for the fp_align_pipe shifter: stage limits, shift-bit allocation, beat flags.
// The guard/round/round-sticky extension is enabled by defining FP_ALIGN_GRS_EN.
package fp_align_pkg;

  localparam int MAX_STAGES = 4;

`ifdef FP_ALIGN_GRS_EN
  localparam int GRS_BITS = 2;
`else
  localparam int GRS_BITS = 0;
`endif

  // Per-beat flags that travel with the data word and the tag through every stage.
  typedef struct packed {
    logic stk;
    logic ovf;
`ifdef FP_ALIGN_GRS_EN
    logic past_grs;
`endif
  } beat_flags_t;

  // Stage k owns shift-amount bits [stage_lo(k) .. stage_lo(k+1)-1].
  function automatic int stage_lo(input int k, input int sh_width, input int num_stages);
    return (k * sh_width) / num_stages;
  endfunction

endpackage

// File: rtl/fp_align_stage.sv
// One pipeline slice: applies its share of the right shift, folds shifted-out bits into sticky,
// and holds the beat in a valid/ready register.
module fp_align_stage
  import fp_align_pkg::*;
#(
  parameter int W         = 23,
  parameter int SH_WIDTH  = 8,
  parameter int TAG_WIDTH = 4,
  parameter int SH_LO     = 0,
  parameter int SH_HI     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [W-1:0]         up_data,
  input  logic [SH_WIDTH-1:0]  up_sh,
  input  beat_flags_t          up_flags,
  input  logic [TAG_WIDTH-1:0] up_tag,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [W-1:0]         dn_data,
  output logic [SH_WIDTH-1:0]  dn_sh,
  output beat_flags_t          dn_flags,
  output logic [TAG_WIDTH-1:0] dn_tag
);

  logic [SH_WIDTH-1:0] amt_s;
  logic [W-1:0]        lost_s;
  beat_flags_t         flags_s;
  logic                load_s;

  assign load_s   = !dn_valid || dn_ready;
  assign up_ready = load_s;

  // Shift by the bits this stage owns; anything pushed off the bottom joins the sticky
  always_comb begin
    amt_s = '0;
    for (int i = 0; i < SH_WIDTH; i++) begin
      if (i >= SH_LO && i < SH_HI) begin
        amt_s[i] = up_sh[i];
      end else begin
        amt_s[i] = 1'b0;
      end
    end
    lost_s      = up_data & ~({W{1'b1}} << amt_s);
    flags_s     = up_flags;
    flags_s.stk = up_flags.stk | (|lost_s);
  end

  // Beat register: loads when empty or when the downstream side takes the current beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_sh    <= '0;
      dn_flags <= '0;
      dn_tag   <= '0;
    end else if (load_s) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data  <= up_data >> amt_s;
        dn_sh    <= up_sh;
        dn_flags <= flags_s;
        dn_tag   <= up_tag;
      end
    end
  end

endmodule

// File: rtl/fp_align_pipe.sv
// Pipelined zero-fill right shifter with sticky and overflow flags and a pass-through tag.
// Defining FP_ALIGN_GRS_EN adds out_grd/out_rnd/out_rstk, carried as two extra low data bits.
module fp_align_pipe
  import fp_align_pkg::*;
#(
  parameter int A_WIDTH    = 23,
  parameter int SH_WIDTH   = 8,
  parameter int NUM_STAGES = 2,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [SH_WIDTH-1:0]  in_sh,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_WIDTH-1:0]   out_b,
  output logic                 out_stk,
  output logic                 out_ovf,
`ifdef FP_ALIGN_GRS_EN
  output logic                 out_grd,
  output logic                 out_rnd,
  output logic                 out_rstk,
`endif
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int W  = A_WIDTH + GRS_BITS;
  localparam int XW = SH_WIDTH + 32;

  logic [XW-1:0] sh_wide;
  logic [W-1:0]  head_data;
  beat_flags_t   head_flags;
  logic [W-1:0]  tail_data;
  beat_flags_t   tail_flags;

  assign sh_wide = {32'd0, in_sh};
`ifdef FP_ALIGN_GRS_EN
  assign head_data = {in_a, 2'b00};
`else
  assign head_data = in_a;
`endif

  // Range decisions need the whole shift amount, so they are taken once on entry
  always_comb begin
    head_flags     = '0;
    head_flags.ovf = (sh_wide >= XW'(A_WIDTH));
`ifdef FP_ALIGN_GRS_EN
    head_flags.past_grs = (sh_wide > XW'(A_WIDTH + 1));
`endif
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic                 up_valid, up_ready, dn_valid, dn_ready;
    logic [W-1:0]         up_data, dn_data;
    logic [SH_WIDTH-1:0]  up_sh, dn_sh;
    beat_flags_t          up_flags, dn_flags;
    logic [TAG_WIDTH-1:0] up_tag, dn_tag;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = head_data;
      assign up_sh    = in_sh;
      assign up_flags = head_flags;
      assign up_tag   = in_tag;
    end else begin : g_link
      assign up_valid = g_stage[k-1].dn_valid;
      assign up_data  = g_stage[k-1].dn_data;
      assign up_sh    = g_stage[k-1].dn_sh;
      assign up_flags = g_stage[k-1].dn_flags;
      assign up_tag   = g_stage[k-1].dn_tag;
    end

    if (k == NUM_STAGES - 1) begin : g_tail
      logic [SH_WIDTH-1:0] unused_sh;
      assign dn_ready  = out_ready;
      assign unused_sh = dn_sh;
    end else begin : g_next
      assign dn_ready = g_stage[k+1].up_ready;
    end

    fp_align_stage #(
      .W         (W),
      .SH_WIDTH  (SH_WIDTH),
      .TAG_WIDTH (TAG_WIDTH),
      .SH_LO     (stage_lo(k, SH_WIDTH, NUM_STAGES)),
      .SH_HI     (stage_lo(k + 1, SH_WIDTH, NUM_STAGES))
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_valid),
      .up_ready (up_ready),
      .up_data  (up_data),
      .up_sh    (up_sh),
      .up_flags (up_flags),
      .up_tag   (up_tag),
      .dn_valid (dn_valid),
      .dn_ready (dn_ready),
      .dn_data  (dn_data),
      .dn_sh    (dn_sh),
      .dn_flags (dn_flags),
      .dn_tag   (dn_tag)
    );
  end

  assign in_ready   = g_stage[0].up_ready;
  assign out_valid  = g_stage[NUM_STAGES-1].dn_valid;
  assign tail_data  = g_stage[NUM_STAGES-1].dn_data;
  assign tail_flags = g_stage[NUM_STAGES-1].dn_flags;
  assign out_tag    = g_stage[NUM_STAGES-1].dn_tag;
  assign out_b      = tail_data[W-1 -: A_WIDTH];
  assign out_ovf    = tail_flags.ovf;

  // The two extension bits hold a[sh-1] and a[sh-2]; the carried sticky covers everything below
`ifdef FP_ALIGN_GRS_EN
  assign out_stk  = tail_flags.stk | tail_data[1] | tail_data[0];
  assign out_grd  = !tail_flags.past_grs && tail_data[1];
  assign out_rnd  = !tail_flags.past_grs && tail_data[0];
  assign out_rstk = !tail_flags.past_grs && tail_flags.stk;
`else
  assign out_stk = tail_flags.stk;
`endif

endmodule

// File: tb/tb_fp_align_pipe.sv
// Self-checking bench for fp_align_pipe (A_WIDTH=8, SH_WIDTH=8, NUM_STAGES=2, TAG_WIDTH=4).
// Directed table, backpressure/throughput sequences, reset-in-flight, and a queue-based scoreboard.
module tb_fp_align_pipe;
  localparam int AW = 8;
  localparam int SW = 8;
  localparam int NS = 2;
  localparam int TW = 4;
  localparam int NV = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] in_a = '0;
  logic [SW-1:0] in_sh = '0;
  logic [TW-1:0] in_tag = '0;
  logic          in_ready, out_valid, out_stk, out_ovf;
  logic [AW-1:0] out_b;
  logic [TW-1:0] out_tag;
`ifdef FP_ALIGN_GRS_EN
  logic          out_grd, out_rnd, out_rstk;
`endif

  fp_align_pipe #(.A_WIDTH(AW), .SH_WIDTH(SW), .NUM_STAGES(NS), .TAG_WIDTH(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_sh     (in_sh),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_b     (out_b),
    .out_stk   (out_stk),
    .out_ovf   (out_ovf),
`ifdef FP_ALIGN_GRS_EN
    .out_grd   (out_grd),
    .out_rnd   (out_rnd),
    .out_rstk  (out_rstk),
`endif
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       stk, ovf, grd, rnd, rstk;
    logic [3:0] tag;
  } beat_t;

  typedef struct {
    logic [7:0] a, sh, b;
    logic       stk, ovf, grd, rnd, rstk;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    n_pop = 0;
  bit    mon_en = 1'b0;
  beat_t exp_q[$];
  vec_t  vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: bit-by-bit reading of the shift rules, no pipelining involved.
  function automatic beat_t ref_beat(input logic [7:0] a, input logic [7:0] sh, input logic [3:0] tag);
    beat_t r;
    int    s;
    s     = int'(sh);
    r.tag = tag;
    r.ovf = (s >= AW);
    r.b   = (s >= AW) ? 8'h00 : (a >> s);
    r.stk = 1'b0;
    r.rstk = 1'b0;
    for (int i = 0; i < AW; i++) begin
      if (i < s) r.stk = r.stk | a[i];
      if (i < s - 2) r.rstk = r.rstk | a[i];
    end
    r.grd = (s >= 1 && s - 1 < AW) ? a[s-1] : 1'b0;
    r.rnd = (s >= 2 && s - 2 < AW) ? a[s-2] : 1'b0;
    if (s > AW + 1) begin
      r.grd = 1'b0;
      r.rnd = 1'b0;
      r.rstk = 1'b0;
    end
    return r;
  endfunction

  task automatic push_beat(input logic [7:0] a, input logic [7:0] sh, input logic [3:0] tag,
                           input bit rnd_rdy, output int cycles);
    bit acc;
    acc = 1'b0;
    cycles = 0;
    in_a = a; in_sh = sh; in_tag = tag; in_valid = 1'b1;
    while (!acc && cycles < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      cycles++;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_timeout: tag %0h not accepted within %0d cycles", tag, cycles);
    end
  endtask

  // Scoreboard: record accepted beats, compare emitted beats in order, watch held outputs.
  initial begin : monitor
    beat_t       e;
    bit          hold;
    logic [13:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) check("hold_stable", 32'({out_valid, out_b, out_stk, out_ovf, out_tag}), 32'({1'b1, held}));
        if (in_valid && in_ready) exp_q.push_back(ref_beat(in_a, in_sh, in_tag));
        if (out_valid && out_ready) begin
          hold = 1'b0;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_extra: beat tag %0h emitted with nothing expected", out_tag);
          end else begin
            e = exp_q.pop_front();
            n_pop++;
            check("sb_tag", 32'(out_tag), 32'(e.tag));
            check("sb_b", 32'(out_b), 32'(e.b));
            check("sb_stk", 32'(out_stk), 32'(e.stk));
            check("sb_ovf", 32'(out_ovf), 32'(e.ovf));
`ifdef FP_ALIGN_GRS_EN
            check("sb_grs", 32'({out_grd, out_rnd, out_rstk}), 32'({e.grd, e.rnd, e.rstk}));
`endif
          end
        end else if (out_valid) begin
          hold = 1'b1;
          held = {out_b, out_stk, out_ovf, out_tag};
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc, n;
    logic [7:0] ra, rs;

    //            a      sh     b      stk   ovf   grd   rnd   rstk
    vecs[0]  = '{8'hB4, 8'd3,   8'h16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8'hB4, 8'd2,   8'h2D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'hB4, 8'd0,   8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h01, 8'd8,   8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{8'h01, 8'd255, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'h00, 8'd200, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'hFF, 8'd9,   8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{8'h81, 8'd1,   8'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{8'h80, 8'd7,   8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'h6C, 8'd4,   8'h06, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{8'h01, 8'd16,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_b", 32'(out_b), 32'(0));
    check("rst_flags", 32'({out_stk, out_ovf}), 32'(0));
    check("rst_out_tag", 32'(out_tag), 32'(0));
`ifdef FP_ALIGN_GRS_EN
    check("rst_grs", 32'({out_grd, out_rnd, out_rstk}), 32'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'(1));
    out_ready = 1'b1;
    mon_en = 1'b1;

    // Directed table, one beat at a time with latency checks
    for (int k = 0; k < NV; k++) begin
      in_a = vecs[k].a; in_sh = vecs[k].sh; in_tag = 4'(k); in_valid = 1'b1;
      check($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid_early", k), 32'(out_valid), 32'(0));
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", k), 32'(out_valid), 32'(1));
      check($sformatf("vec%0d_b", k), 32'(out_b), 32'(vecs[k].b));
      check($sformatf("vec%0d_stk", k), 32'(out_stk), 32'(vecs[k].stk));
      check($sformatf("vec%0d_ovf", k), 32'(out_ovf), 32'(vecs[k].ovf));
      check($sformatf("vec%0d_tag", k), 32'(out_tag), 32'(k));
`ifdef FP_ALIGN_GRS_EN
      check($sformatf("vec%0d_grs", k), 32'({out_grd, out_rnd, out_rstk}),
            32'({vecs[k].grd, vecs[k].rnd, vecs[k].rstk}));
`endif
    end
    @(posedge clk); #1;

    // Backpressure fill, then 20 random beats under 50% out_ready
    n_pop = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 9));
      push_beat(ra, rs, 4'(k), (k >= 2), cyc);
      if (k == 0) check("fill_in_ready_after_1", 32'(in_ready), 32'(1));
      if (k == 1) begin
        in_valid = 1'b0;
        check("fill_in_ready_low", 32'(in_ready), 32'(0));
        check("fill_out_valid", 32'(out_valid), 32'(1));
        @(posedge clk); #1;
        check("fill_in_ready_still_low", 32'(in_ready), 32'(0));
        out_ready = 1'b1;
        #1;
        check("full_pipe_in_ready_with_out_ready", 32'(in_ready), 32'(1));
      end
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_empty", 32'(exp_q.size()), 32'(0));
    check("drain_count", 32'(n_pop), 32'(20));
    check("drain_out_valid", 32'(out_valid), 32'(0));

    // Full throughput: out_ready held high, each beat accepted in one cycle
    for (int k = 0; k < 8; k++) begin
      push_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 10)), 4'(k + 3), 1'b0, cyc);
      check($sformatf("thru%0d_cycles", k), 32'(cyc), 32'(1));
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("thru_drain_empty", 32'(exp_q.size()), 32'(0));

    // Reset with two beats in flight
    mon_en = 1'b0;
    out_ready = 1'b0;
    push_beat(8'hFF, 8'd1, 4'h5, 1'b0, cyc);
    push_beat(8'hF0, 8'd2, 4'h6, 1'b0, cyc);
    in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_out_b", 32'(out_b), 32'(0));
    check("midrst_out_tag", 32'(out_tag), 32'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("no_stale%0d", k), 32'(out_valid), 32'(0));
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
